// File: rtl/pixel_readout_mux.sv
// Registered N:1 column-bus mux with manual single-shot and auto-scan modes; 1 cycle capture-to-output.
// Backpressure: a beat holds stable while out_valid && !out_ready; no capture (and no scan advance) until accepted.
module pixel_readout_mux #(
    parameter int N_CHANNELS = 4,
    parameter int BUS_WIDTH  = 8,
    parameter int SEL_WIDTH  = $clog2(N_CHANNELS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            mode,
    input  logic                            start,
    input  logic [SEL_WIDTH-1:0]            select,
    input  logic [N_CHANNELS*BUS_WIDTH-1:0] in_data,
    output logic [BUS_WIDTH-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]            out_chan,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            busy,
    output logic                            sel_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAN  = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;

    localparam logic [SEL_WIDTH-1:0] LAST_CHAN  = SEL_WIDTH'(N_CHANNELS - 1);
    localparam logic [SEL_WIDTH:0]   N_CHAN_EXT = (SEL_WIDTH + 1)'(N_CHANNELS);

    // Out-of-range indices fall through every match and yield zero.
    function automatic logic [BUS_WIDTH-1:0] chan_word(
        input logic [SEL_WIDTH-1:0]            idx,
        input logic [N_CHANNELS*BUS_WIDTH-1:0] bus
    );
        logic [BUS_WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            if (idx == SEL_WIDTH'(k)) begin
                w = bus[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
        return w;
    endfunction

    logic [1:0]           state_q, state_d;
    logic [SEL_WIDTH-1:0] cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0] out_chan_q, out_chan_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 sel_err_q, sel_err_d;
    logic                 cap_ok;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        sel_err_d   = sel_err_q;
        cap_ok      = !out_valid_q || out_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mode) begin
                        state_d = S_SCAN;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_MAN;
                    end
                end
            end
            S_MAN: begin
                if (cap_ok) begin
                    out_data_d  = chan_word(select, in_data);
                    out_chan_d  = select;
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                    if ({1'b0, select} >= N_CHAN_EXT) begin
                        sel_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (cap_ok) begin
                    out_data_d  = chan_word(cnt_q, in_data);
                    out_chan_d  = cnt_q;
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == LAST_CHAN);
                    if (cnt_q == LAST_CHAN) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign sel_err   = sel_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pixel_readout_mux.sv
// Bench for pixel_readout_mux: a 4-channel and a 3-channel instance sharing one clock and reset.
module tb_pixel_readout_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mode4, start4, ready4, v4, l4, b4, e4;
    logic [1:0]  sel4, c4;
    logic [31:0] in4;
    logic [7:0]  d4;
    logic        mode3, start3, ready3, v3, l3, b3, e3;
    logic [1:0]  sel3, c3;
    logic [23:0] in3;
    logic [7:0]  d3;

    pixel_readout_mux #(.N_CHANNELS(4), .BUS_WIDTH(8)) dut4 (
        .clk(clk), .reset(reset), .mode(mode4), .start(start4), .select(sel4),
        .in_data(in4), .out_data(d4), .out_chan(c4), .out_valid(v4),
        .out_ready(ready4), .out_last(l4), .busy(b4), .sel_err(e4)
    );

    pixel_readout_mux #(.N_CHANNELS(3), .BUS_WIDTH(8)) dut3 (
        .clk(clk), .reset(reset), .mode(mode3), .start(start3), .select(sel3),
        .in_data(in3), .out_data(d3), .out_chan(c3), .out_valid(v3),
        .out_ready(ready3), .out_last(l3), .busy(b3), .sel_err(e3)
    );

    typedef struct {
        logic [7:0] d;
        logic [1:0] c;
        logic       l;
        int         cyc;
    } beat_t;

    typedef struct {
        bit         on3;
        logic [1:0] sel;
        logic [7:0] exp_d;
        logic       exp_err;
    } vec_t;

    beat_t got4[$];
    beat_t got3[$];
    beat_t exp_q[$];
    vec_t  tbl[8];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Inputs for the coming edge are already driven, so a handshake seen here is the one that edge takes.
    task automatic step();
        if (v4 && ready4) got4.push_back('{d4, c4, l4, cyc_n});
        if (v3 && ready3) got3.push_back('{d3, c3, l3, cyc_n});
        @(negedge clk);
        cyc_n++;
    endtask

    // Reference: the list of beats a request must produce on the 4-channel instance.
    task automatic build_exp(input logic m, input logic [1:0] s, input logic [31:0] din);
        exp_q.delete();
        if (m) begin
            for (int k = 0; k < 4; k++) exp_q.push_back('{din[k*8 +: 8], 2'(k), (k == 3), 0});
        end else begin
            exp_q.push_back('{din[s*8 +: 8], s, 1'b1, 0});
        end
    endtask

    task automatic cmp_beats(input string name);
        chk({name, " count"}, got4.size(), exp_q.size());
        for (int i = 0; i < got4.size() && i < exp_q.size(); i++) begin
            chk({name, " data"}, got4[i].d, exp_q[i].d);
            chk({name, " chan"}, got4[i].c, exp_q[i].c);
            chk({name, " last"}, got4[i].l, exp_q[i].l);
        end
    endtask

    task automatic run(input bit on3, input logic m, input logic [1:0] s, input bit rnd, input int budget);
        bit done;
        done = 1'b0;
        if (on3) begin
            mode3 = m; sel3 = s; ready3 = 1'b1; start3 = 1'b1;
        end else begin
            mode4 = m; sel4 = s; ready4 = 1'b1; start4 = 1'b1;
        end
        step();
        start3 = 1'b0;
        start4 = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rnd) ready4 = 1'($urandom % 2);
            if (rnd && m) begin
                mode4 = 1'($urandom % 2);
                sel4  = 2'($urandom % 4);
            end
            step();
            if (on3 ? (!b3 && !v3) : (!b4 && !v4)) begin
                done = 1'b1;
                break;
            end
        end
        chk("run completes", done, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        mode4 = 0; start4 = 0; ready4 = 0; sel4 = 0; in4 = 32'h44332211;
        mode3 = 0; start3 = 0; ready3 = 0; sel3 = 0; in3 = 24'h332211;
        repeat (3) @(negedge clk);

        chk("reset data", d4, 8'h00);
        chk("reset chan", c4, 2'd0);
        chk("reset valid", v4, 1'b0);
        chk("reset last", l4, 1'b0);
        chk("reset busy", b4, 1'b0);
        chk("reset sel_err", e4, 1'b0);
        chk("reset valid n3", v3, 1'b0);
        chk("reset sel_err n3", e3, 1'b0);
        reset = 1'b1;
        step();

        // Full-rate scan: four beats on four consecutive cycles.
        got4.delete();
        run(0, 1'b1, 2'd0, 0, 20);
        build_exp(1'b1, 2'd0, in4);
        cmp_beats("scan");
        for (int k = 1; k < got4.size(); k++) chk("scan consecutive", got4[k].cyc, got4[0].cyc + k);
        chk("scan busy after", b4, 1'b0);

        // Scan with a three-cycle stall on the first beat.
        got4.delete();
        mode4 = 1; ready4 = 1; start4 = 1;
        step();
        start4 = 0;
        chk("stall busy", b4, 1'b1);
        for (int i = 0; i < 10 && !v4; i++) step();
        chk("stall first beat", v4, 1'b1);
        ready4 = 0;
        repeat (3) begin
            step();
            chk("stall data", d4, 8'h11);
            chk("stall chan", c4, 2'd0);
            chk("stall valid", v4, 1'b1);
        end
        ready4 = 1;
        for (int i = 0; i < 20 && (b4 || v4); i++) step();
        chk("stall drain", b4 | v4, 1'b0);
        build_exp(1'b1, 2'd0, in4);
        cmp_beats("stall scan");

        // Manual single samples; the 3-channel rows exercise the sticky range error.
        tbl[0] = '{0, 2'd2, 8'h33, 1'b0};
        tbl[1] = '{0, 2'd0, 8'h11, 1'b0};
        tbl[2] = '{0, 2'd3, 8'h44, 1'b0};
        tbl[3] = '{0, 2'd1, 8'h22, 1'b0};
        tbl[4] = '{1, 2'd1, 8'h22, 1'b0};
        tbl[5] = '{1, 2'd3, 8'h00, 1'b1};
        tbl[6] = '{1, 2'd0, 8'h11, 1'b1};
        tbl[7] = '{1, 2'd2, 8'h33, 1'b1};
        for (int i = 0; i < 8; i++) begin
            got4.delete();
            got3.delete();
            run(tbl[i].on3, 1'b0, tbl[i].sel, 0, 20);
            if (tbl[i].on3) begin
                chk("man3 count", got3.size(), 1);
                if (got3.size() > 0) begin
                    chk("man3 data", got3[0].d, tbl[i].exp_d);
                    chk("man3 chan", got3[0].c, tbl[i].sel);
                    chk("man3 last", got3[0].l, 1'b1);
                end
                chk("man3 sel_err", e3, tbl[i].exp_err);
                chk("man3 busy", b3, 1'b0);
            end else begin
                chk("man4 count", got4.size(), 1);
                if (got4.size() > 0) begin
                    chk("man4 data", got4[0].d, tbl[i].exp_d);
                    chk("man4 chan", got4[0].c, tbl[i].sel);
                    chk("man4 last", got4[0].l, 1'b1);
                end
                chk("man4 sel_err", e4, tbl[i].exp_err);
                chk("man4 busy", b4, 1'b0);
            end
        end

        // Reset asserted after the second beat of a scan clears outputs without a clock edge.
        got4.delete();
        mode4 = 1; ready4 = 1; start4 = 1;
        step();
        start4 = 0;
        for (int i = 0; i < 20 && got4.size() < 2; i++) step();
        chk("pre-reset beats", got4.size(), 2);
        reset = 1'b0;
        #1;
        chk("async data", d4, 8'h00);
        chk("async chan", c4, 2'd0);
        chk("async valid", v4, 1'b0);
        chk("async last", l4, 1'b0);
        chk("async busy", b4, 1'b0);
        chk("async sel_err n3", e3, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step();
        got4.delete();
        run(0, 1'b1, 2'd0, 0, 20);
        build_exp(1'b1, 2'd0, in4);
        cmp_beats("post-reset scan");

        // start re-pulsed and mode toggled while a stalled scan is in flight.
        got4.delete();
        in4 = 32'hA5C3_0F96;
        mode4 = 1; ready4 = 1; start4 = 1;
        step();
        start4 = 0; ready4 = 0;
        step();
        step();
        start4 = 1; mode4 = 0; sel4 = 2'd2;
        step();
        start4 = 0; mode4 = 1;
        step();
        mode4 = 0; ready4 = 1;
        for (int i = 0; i < 20 && (b4 || v4); i++) step();
        repeat (5) step();
        build_exp(1'b1, 2'd0, in4);
        cmp_beats("ignored start");

        // Random requests with random backpressure against the reference beat list.
        for (int it = 0; it < 25; it++) begin
            logic       m;
            logic [1:0] s;
            in4 = $urandom;
            m   = 1'($urandom % 2);
            s   = 2'($urandom % 4);
            got4.delete();
            run(0, m, s, 1, 300);
            ready4 = 1;
            build_exp(m, s, in4);
            cmp_beats("random");
        end
        chk("random sel_err", e4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
